// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller.
// A registered 3-bit state walks FETCH/DECODE/EXE/MEM/WB. Every control output
// is decoded combinationally from the current state and the live op/funct/zero/
// mem_ready inputs, and is forced quiet while reset is held low.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       mem_req,
  output logic       instr_done,
  output logic [1:0] M2Sel,
  output logic [1:0] RegDst,
  output logic [1:0] NPCSel,
  output logic [2:0] ALUOp,
  output logic       ALUSrc,
  output logic       ExtOp,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH  = 3'b000;
  localparam logic [2:0] S_DECODE = 3'b001;
  localparam logic [2:0] S_EXE    = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB     = 3'b100;

  typedef enum logic [3:0] {
    I_ADDU = 4'd0,
    I_SUBU = 4'd1,
    I_JR   = 4'd2,
    I_ORI  = 4'd3,
    I_LW   = 4'd4,
    I_SW   = 4'd5,
    I_BEQ  = 4'd6,
    I_LUI  = 4'd7,
    I_J    = 4'd8,
    I_JAL  = 4'd9,
    I_ILL  = 4'd10
  } instr_e;

  logic [2:0] state_q;
  logic [2:0] state_d;
  instr_e     instr_s;

  assign state = state_q;

  // Classify the held instruction word; anything unrecognised is illegal.
  always_comb begin
    instr_s = I_ILL;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100001: instr_s = I_ADDU;
          6'b100011: instr_s = I_SUBU;
          6'b001000: instr_s = I_JR;
          default:   instr_s = I_ILL;
        endcase
      end
      6'b001101: instr_s = I_ORI;
      6'b100011: instr_s = I_LW;
      6'b101011: instr_s = I_SW;
      6'b000100: instr_s = I_BEQ;
      6'b001111: instr_s = I_LUI;
      6'b000010: instr_s = I_J;
      6'b000011: instr_s = I_JAL;
      default:   instr_s = I_ILL;
    endcase
  end

  // State register: reset drops straight back to FETCH without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (instr_s)
          I_J, I_JR, I_ILL: state_d = S_FETCH;
          I_JAL:            state_d = S_WB;
          default:          state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        case (instr_s)
          I_LW, I_SW:                   state_d = S_MEM;
          I_ADDU, I_SUBU, I_ORI, I_LUI: state_d = S_WB;
          default:                      state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!mem_ready && (instr_s == I_LW || instr_s == I_SW)) begin
          state_d = S_MEM;
        end else if (instr_s == I_LW) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Control outputs: everything idles at zero unless the current state/instruction claims it.
  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    mem_req    = 1'b0;
    instr_done = 1'b0;
    M2Sel      = 2'b00;
    RegDst     = 2'b00;
    NPCSel     = 2'b00;
    ALUOp      = 3'b000;
    ALUSrc     = 1'b0;
    ExtOp      = 1'b0;
    if (!reset) begin
      PCWrite = 1'b0;
    end else begin
      instr_done = (state_q != S_FETCH) && (state_d == S_FETCH);
      case (state_q)
        S_FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        S_DECODE: begin
          case (instr_s)
            I_J: begin
              PCWrite = 1'b1;
              NPCSel  = 2'b10;
            end
            I_JR: begin
              PCWrite = 1'b1;
              NPCSel  = 2'b11;
            end
            default: PCWrite = 1'b0;
          endcase
        end
        S_EXE: begin
          case (instr_s)
            I_SUBU: ALUOp = 3'b001;
            I_ORI: begin
              ALUOp  = 3'b010;
              ALUSrc = 1'b1;
            end
            I_LUI: begin
              ALUOp  = 3'b011;
              ALUSrc = 1'b1;
            end
            I_LW, I_SW: begin
              ALUSrc = 1'b1;
              ExtOp  = 1'b1;
            end
            I_BEQ: begin
              ALUOp   = 3'b001;
              ExtOp   = 1'b1;
              PCWrite = zero;
              NPCSel  = 2'b01;
            end
            default: ALUOp = 3'b000;
          endcase
        end
        S_MEM: begin
          if (instr_s == I_LW || instr_s == I_SW) begin
            mem_req  = 1'b1;
            MemWrite = (instr_s == I_SW);
          end else begin
            mem_req = 1'b0;
          end
        end
        S_WB: begin
          case (instr_s)
            I_ADDU, I_SUBU: begin
              RegWrite = 1'b1;
              RegDst   = 2'b01;
            end
            I_ORI, I_LUI: RegWrite = 1'b1;
            I_LW: begin
              RegWrite = 1'b1;
              M2Sel    = 2'b01;
            end
            I_JAL: begin
              RegWrite = 1'b1;
              M2Sel    = 2'b10;
              RegDst   = 2'b10;
            end
            default: RegWrite = 1'b0;
          endcase
        end
        default: PCWrite = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle vector table plus an async-reset sequence.
module tb_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, mem_req, instr_done;
  logic [1:0] M2Sel, RegDst, NPCSel;
  logic [2:0] ALUOp;
  logic       ALUSrc, ExtOp;
  logic [2:0] state;

  int total;
  int bad;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .mem_req(mem_req),
    .instr_done(instr_done), .M2Sel(M2Sel), .RegDst(RegDst),
    .NPCSel(NPCSel), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .ExtOp(ExtOp),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       z;
    logic       mr;
    logic [2:0] st;
    logic [5:0] en;   // {PCWrite, IRWrite, RegWrite, MemWrite, mem_req, instr_done}
    logic [1:0] m2;
    logic [1:0] rd;
    logic [1:0] npc;
    logic [2:0] alu;
    logic       src;
    logic       ext;
  } vec_t;

  vec_t tbl[$];

  localparam logic [5:0] OPR = 6'b000000, OPORI = 6'b001101, OPLW = 6'b100011;
  localparam logic [5:0] OPSW = 6'b101011, OPBEQ = 6'b000100, OPLUI = 6'b001111;
  localparam logic [5:0] OPJ = 6'b000010, OPJAL = 6'b000011, OPILL = 6'b111111;
  localparam logic [5:0] FADDU = 6'b100001, FSUBU = 6'b100011, FJR = 6'b001000;
  localparam logic [5:0] F0 = 6'b000000;
  localparam logic [5:0] EN_F = 6'b110000, EN_WB = 6'b001001, EN_DONE = 6'b000001;

  task automatic add(input string n, input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic mr, input logic [2:0] st, input logic [5:0] en,
                     input logic [1:0] m2, input logic [1:0] rd, input logic [1:0] npc,
                     input logic [2:0] alu, input logic src, input logic ext);
    vec_t v;
    v.name = n; v.rst = r; v.op = o; v.funct = f; v.z = z; v.mr = mr; v.st = st;
    v.en = en; v.m2 = m2; v.rd = rd; v.npc = npc; v.alu = alu; v.src = src; v.ext = ext;
    tbl.push_back(v);
  endtask

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  function automatic logic [19:0] pack_out();
    return {state, PCWrite, IRWrite, RegWrite, MemWrite, mem_req, instr_done,
            M2Sel, RegDst, NPCSel, ALUOp, ALUSrc, ExtOp};
  endfunction

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0; op = 6'b000000; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b0;

    //   name         rst op     funct  z  mr st      en        m2     rd     npc    alu     src  ext
    add("rst0",       0, OPR,   FADDU, 0, 0, 3'd0, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("rst1",       0, OPR,   FADDU, 0, 0, 3'd0, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("addu_f",     1, OPR,   FADDU, 0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("addu_d",     1, OPR,   FADDU, 0, 0, 3'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("addu_e",     1, OPR,   FADDU, 0, 0, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("addu_w",     1, OPR,   FADDU, 0, 0, 3'd4, EN_WB,     2'b00, 2'b01, 2'b00, 3'b000, 0, 0);
    add("subu_f",     1, OPR,   FSUBU, 0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("subu_d",     1, OPR,   FSUBU, 0, 0, 3'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("subu_e",     1, OPR,   FSUBU, 0, 0, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b001, 0, 0);
    add("subu_w",     1, OPR,   FSUBU, 0, 0, 3'd4, EN_WB,     2'b00, 2'b01, 2'b00, 3'b000, 0, 0);
    add("ori_f",      1, OPORI, F0,    0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("ori_d",      1, OPORI, F0,    0, 0, 3'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("ori_e",      1, OPORI, F0,    0, 0, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b010, 1, 0);
    add("ori_w",      1, OPORI, F0,    0, 0, 3'd4, EN_WB,     2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("lui_f",      1, OPLUI, F0,    0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("lui_d",      1, OPLUI, F0,    0, 0, 3'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("lui_e",      1, OPLUI, F0,    0, 0, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b011, 1, 0);
    add("lui_w",      1, OPLUI, F0,    0, 0, 3'd4, EN_WB,     2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("lw_f",       1, OPLW,  F0,    0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("lw_d",       1, OPLW,  F0,    0, 0, 3'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("lw_e",       1, OPLW,  F0,    0, 0, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1);
    add("lw_m0",      1, OPLW,  F0,    0, 0, 3'd3, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("lw_m1",      1, OPLW,  F0,    0, 0, 3'd3, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("lw_m2",      1, OPLW,  F0,    0, 0, 3'd3, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("lw_m3",      1, OPLW,  F0,    0, 1, 3'd3, 6'b000010, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("lw_w",       1, OPLW,  F0,    0, 0, 3'd4, EN_WB,     2'b01, 2'b00, 2'b00, 3'b000, 0, 0);
    add("sw_f",       1, OPSW,  F0,    0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("sw_d",       1, OPSW,  F0,    0, 0, 3'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("sw_e",       1, OPSW,  F0,    0, 0, 3'd2, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 1, 1);
    add("sw_m",       1, OPSW,  F0,    0, 1, 3'd3, 6'b000111, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("beq1_f",     1, OPBEQ, F0,    1, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("beq1_d",     1, OPBEQ, F0,    1, 0, 3'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("beq1_e",     1, OPBEQ, F0,    1, 0, 3'd2, 6'b100001, 2'b00, 2'b00, 2'b01, 3'b001, 0, 1);
    add("beq0_f",     1, OPBEQ, F0,    0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("beq0_d",     1, OPBEQ, F0,    0, 0, 3'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("beq0_e",     1, OPBEQ, F0,    0, 0, 3'd2, EN_DONE,   2'b00, 2'b00, 2'b01, 3'b001, 0, 1);
    add("j_f",        1, OPJ,   F0,    0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("j_d",        1, OPJ,   F0,    0, 0, 3'd1, 6'b100001, 2'b00, 2'b00, 2'b10, 3'b000, 0, 0);
    add("jr_f",       1, OPR,   FJR,   0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("jr_d",       1, OPR,   FJR,   0, 0, 3'd1, 6'b100001, 2'b00, 2'b00, 2'b11, 3'b000, 0, 0);
    add("jal_f",      1, OPJAL, F0,    0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("jal_d",      1, OPJAL, F0,    0, 0, 3'd1, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("jal_w",      1, OPJAL, F0,    0, 0, 3'd4, EN_WB,     2'b10, 2'b10, 2'b00, 3'b000, 0, 0);
    add("ill_f",      1, OPILL, F0,    0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("ill_d",      1, OPILL, F0,    0, 0, 3'd1, EN_DONE,   2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("illf_f",     1, OPR,   F0,    0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("illf_d",     1, OPR,   F0,    0, 0, 3'd1, EN_DONE,   2'b00, 2'b00, 2'b00, 3'b000, 0, 0);
    add("end_f",      1, OPR,   FADDU, 0, 0, 3'd0, EN_F,      2'b00, 2'b00, 2'b00, 3'b000, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; op = tbl[i].op; funct = tbl[i].funct;
      zero = tbl[i].z; mem_ready = tbl[i].mr;
      #1;
      chk(tbl[i].name, {12'd0, pack_out()},
          {12'd0, tbl[i].st, tbl[i].en, tbl[i].m2, tbl[i].rd, tbl[i].npc,
           tbl[i].alu, tbl[i].src, tbl[i].ext});
    end

    // sw stalled in MEM, then reset asserted between clock edges.
    @(negedge clk);
    op = OPSW; funct = F0; zero = 1'b0; mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("swr_in_mem", {29'd0, state, MemWrite, mem_req}, {29'd0, 3'd3, 1'b1, 1'b1});
    reset = 1'b0;
    #1;
    chk("swr_async_state", {29'd0, state}, 32'd0);
    chk("swr_async_outs", {26'd0, PCWrite, IRWrite, RegWrite, MemWrite, mem_req, instr_done},
        32'd0);
    @(posedge clk);
    #1;
    chk("swr_held", {26'd0, state, IRWrite, PCWrite, MemWrite}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("swr_release_fetch", {29'd0, state, IRWrite, PCWrite}, {29'd0, 3'd0, 1'b1, 1'b1});
    @(posedge clk);
    #1;
    chk("swr_first_edge", {29'd0, state}, {29'd0, 3'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
